// File: rtl/dblock_rule_writer.sv
// rtl/dblock_rule_writer.sv - expands ternary rows into 32-entry truth tables and shifts them into a fractional-TCAM block
// Optional shadow row storage with per-row merge: define DBLOCK_RULE_WRITER_SHADOW_EN
module dblock_rule_writer #(
    parameter int KW_SIZE = 5,
    parameter int RD_SIZE = 32,
    parameter int GW      = 2
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [GW-1:0]         req_group,
    input  logic [8*KW_SIZE-1:0]  req_value,
    input  logic [8*KW_SIZE-1:0]  req_mask,
    input  logic [7:0]            req_rvalid,
    input  logic [7:0]            req_rowsel,
    output logic [RD_SIZE/8-1:0]  we,
    output logic [7:0]            rules,
    output logic                  clr,
    output logic                  busy,
    output logic                  done,
    output logic                  done_err
);
    localparam int N_GROUPS = RD_SIZE / 8;
    localparam int RW       = 8 * KW_SIZE;
    localparam logic [KW_SIZE-1:0] KEY_FIRST = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_n;
    logic [KW_SIZE-1:0]  cnt, cnt_n;
    logic [GW-1:0]       grp_q;
    logic                bad_q;
    logic [RW-1:0]       val_q, msk_q;
    logic [7:0]          rv_q;

    logic                accept, req_bad;
    logic [RW-1:0]       in_val, in_msk;
    logic [7:0]          in_rv;

    logic [GW-1:0]       src_grp;
    logic [RW-1:0]       src_val, src_msk;
    logic [7:0]          src_rv;
    logic [KW_SIZE-1:0]  key;
    logic                shifting;

    logic [N_GROUPS-1:0] we_n;
    logic [7:0]          rules_n;
    logic                clr_n, busy_n, done_n, done_err_n;

    // One truth-table entry per row for key k; masked bits never disqualify a match.
    function automatic logic [7:0] expand(input logic [RW-1:0] v, input logic [RW-1:0] m,
                                          input logic [7:0] rv, input logic [KW_SIZE-1:0] k);
        logic [7:0] res;
        for (int r = 0; r < 8; r++) begin
            res[r] = rv[r] & (((k ^ v[r*KW_SIZE +: KW_SIZE]) & ~m[r*KW_SIZE +: KW_SIZE]) == '0);
        end
        return res;
    endfunction

    assign req_ready = (state == IDLE) || (state == DONE);
    assign accept    = req_valid && req_ready;
    assign req_bad   = int'(req_group) >= N_GROUPS;

`ifdef DBLOCK_RULE_WRITER_SHADOW_EN
    logic [RW-1:0] sh_val [N_GROUPS];
    logic [RW-1:0] sh_msk [N_GROUPS];
    logic [7:0]    sh_rv  [N_GROUPS];
    logic [RW-1:0] sh_sel_val, sh_sel_msk;
    logic [7:0]    sh_sel_rv;

    // A bad group has no shadow copy, so unselected rows read as zero (never match).
    always_comb begin
        sh_sel_val = '0;
        sh_sel_msk = '0;
        sh_sel_rv  = '0;
        in_val     = '0;
        in_msk     = '0;
        in_rv      = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (int'(req_group) == g) begin
                sh_sel_val = sh_val[g];
                sh_sel_msk = sh_msk[g];
                sh_sel_rv  = sh_rv[g];
            end
        end
        for (int r = 0; r < 8; r++) begin
            in_val[r*KW_SIZE +: KW_SIZE] = req_rowsel[r] ? req_value[r*KW_SIZE +: KW_SIZE]
                                                         : sh_sel_val[r*KW_SIZE +: KW_SIZE];
            in_msk[r*KW_SIZE +: KW_SIZE] = req_rowsel[r] ? req_mask[r*KW_SIZE +: KW_SIZE]
                                                         : sh_sel_msk[r*KW_SIZE +: KW_SIZE];
            in_rv[r] = req_rowsel[r] ? req_rvalid[r] : sh_sel_rv[r];
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                sh_val[g] <= '0;
                sh_msk[g] <= '0;
                sh_rv[g]  <= '0;
            end
        end else if (accept && !req_bad) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                if (int'(req_group) == g) begin
                    sh_val[g] <= in_val;
                    sh_msk[g] <= in_msk;
                    sh_rv[g]  <= in_rv;
                end
            end
        end
    end
`else
    logic unused_rowsel;
    assign unused_rowsel = ^req_rowsel;
    assign in_val = req_value;
    assign in_msk = req_mask;
    assign in_rv  = req_rvalid;
`endif

    // Outputs are computed one cycle ahead and registered; on acceptance the first
    // entry (key 31) comes straight from the merged request so SHIFT starts at T+1.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shifting   = 1'b0;
        src_grp    = grp_q;
        src_val    = val_q;
        src_msk    = msk_q;
        src_rv     = rv_q;
        key        = cnt - 1'b1;
        we_n       = '0;
        rules_n    = '0;
        clr_n      = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        done_err_n = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_n  = SHIFT;
                    cnt_n    = KEY_FIRST;
                    src_grp  = req_group;
                    src_val  = in_val;
                    src_msk  = in_msk;
                    src_rv   = in_rv;
                    key      = KEY_FIRST;
                    shifting = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_n    = DONE;
                    cnt_n      = KEY_FIRST;
                    done_n     = 1'b1;
                    done_err_n = bad_q;
                end else begin
                    cnt_n    = cnt - 1'b1;
                    shifting = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (shifting) begin
            busy_n  = 1'b1;
            clr_n   = 1'b1;
            rules_n = expand(src_val, src_msk, src_rv, key);
            for (int g = 0; g < N_GROUPS; g++) begin
                we_n[g] = (int'(src_grp) == g);
            end
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= KEY_FIRST;
            grp_q    <= '0;
            bad_q    <= 1'b0;
            val_q    <= '0;
            msk_q    <= '0;
            rv_q     <= '0;
            we       <= '0;
            rules    <= '0;
            clr      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            we       <= we_n;
            rules    <= rules_n;
            clr      <= clr_n;
            busy     <= busy_n;
            done     <= done_n;
            done_err <= done_err_n;
            if (accept) begin
                grp_q <= req_group;
                bad_q <= req_bad;
                val_q <= in_val;
                msk_q <= in_msk;
                rv_q  <= in_rv;
            end
        end
    end
endmodule

// File: tb/tb_dblock_rule_writer.sv
// tb/tb_dblock_rule_writer.sv - directed self-checking bench for dblock_rule_writer
// Built with GW=3 so out-of-range groups can be requested.
module tb_dblock_rule_writer;
    localparam int GW = 3;

    logic        wclk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [GW-1:0] req_group = '0;
    logic [39:0] req_value = '0;
    logic [39:0] req_mask = '0;
    logic [7:0]  req_rvalid = '0;
    logic [7:0]  req_rowsel = '0;
    logic [3:0]  we;
    logic [7:0]  rules;
    logic        clr, busy, done, done_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] cap_we    [1:70];
    logic [7:0] cap_rules [1:70];
    logic       cap_busy  [1:70];
    logic       cap_clr   [1:70];
    logic       cap_done  [1:70];
    logic       cap_err   [1:70];
    logic       cap_ready [1:70];
    logic [7:0] first_rules [1:32];
    logic [31:0] tmem [0:31];

    always #5 wclk = ~wclk;

    dblock_rule_writer #(.KW_SIZE(5), .RD_SIZE(32), .GW(GW)) dut (
        .wclk(wclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_group(req_group), .req_value(req_value), .req_mask(req_mask),
        .req_rvalid(req_rvalid), .req_rowsel(req_rowsel), .we(we), .rules(rules),
        .clr(clr), .busy(busy), .done(done), .done_err(done_err)
    );

    // TCAM block model: each written row shifts its rule bit in at the LSB.
    always @(posedge wclk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) tmem[r] <= '0;
        end else begin
            for (int g = 0; g < 4; g++)
                if (we[g])
                    for (int r = 0; r < 8; r++) tmem[g*8+r] <= {tmem[g*8+r][30:0], rules[r]};
        end
    end

    function automatic logic [31:0] tcam_match(input int sk);
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = tmem[r][sk];
        return m;
    endfunction

    // Row r value = r: only row k matches key k (k < 8).
    function automatic logic [39:0] val_seq();
        logic [39:0] v;
        for (int r = 0; r < 8; r++) v[r*5 +: 5] = 5'(r);
        return v;
    endfunction

    function automatic logic [7:0] diag_rules(input int k);
        logic [7:0] e;
        e = '0;
        if (k < 8) e[k] = 1'b1;
        return e;
    endfunction

    task automatic issue(input logic [GW-1:0] g, input logic [39:0] v, input logic [39:0] m,
                         input logic [7:0] rv, input logic [7:0] rs);
        @(negedge wclk);
        req_group = g; req_value = v; req_mask = m; req_rvalid = rv; req_rowsel = rs;
        req_valid = 1'b1;
        @(posedge wclk);
    endtask

    // Samples cycles T+1..T+n; drops and scrambles the request after the first cycle.
    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge wclk);
            cap_we[i] = we; cap_rules[i] = rules; cap_busy[i] = busy; cap_clr[i] = clr;
            cap_done[i] = done; cap_err[i] = done_err; cap_ready[i] = req_ready;
            if (i == 1) begin
                req_valid = 1'b0;
                req_value = ~req_value; req_mask = ~req_mask;
                req_rvalid = ~req_rvalid; req_rowsel = ~req_rowsel;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({req_ready, we, rules, clr, busy, done, done_err} !== {1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_asserted: got %b want %b", {req_ready, we, rules, clr, busy, done, done_err}, {1'b1, 16'h0});
        end
        repeat (2) @(negedge wclk);
        rst = 1'b0;
        @(negedge wclk);
        n_cmp++;
        if ({req_ready, we, rules, clr, busy, done, done_err} !== {1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want %b", {req_ready, we, rules, clr, busy, done, done_err}, {1'b1, 16'h0});
        end
    endtask

    task automatic test_single_row();
        logic [31:0] m;
        issue(3'd0, 40'h15, 40'h0, 8'h01, 8'hFF);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if (cap_rules[i] !== ((i == 11) ? 8'h01 : 8'h00)) begin
                n_bad++;
                $display("FAIL single_rules[%0d]: got %h want %h", i, cap_rules[i], (i == 11) ? 8'h01 : 8'h00);
            end
            n_cmp++;
            if ({cap_we[i], cap_busy[i], cap_clr[i], cap_done[i]} !== 7'b0001_110) begin
                n_bad++;
                $display("FAIL single_ctl[%0d]: got %b want 0001110", i, {cap_we[i], cap_busy[i], cap_clr[i], cap_done[i]});
            end
        end
        n_cmp++;
        if ({cap_done[33], cap_err[33], cap_busy[33], cap_we[33]} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL single_done: got %b want 1000000", {cap_done[33], cap_err[33], cap_busy[33], cap_we[33]});
        end
        m = tcam_match(21);
        n_cmp++;
        if (m !== 32'h1) begin n_bad++; $display("FAIL tcam_sk21: got %h want 00000001", m); end
        m = tcam_match(20);
        n_cmp++;
        if (m !== 32'h0) begin n_bad++; $display("FAIL tcam_sk20: got %h want 00000000", m); end
    endtask

    task automatic test_all_dontcare();
        issue(3'd2, 40'h12_3456_789A, 40'hFF_FFFF_FFFF, 8'hFF, 8'hFF);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if ({cap_rules[i], cap_we[i], cap_busy[i], cap_clr[i], cap_done[i]} !== {8'hFF, 4'b0100, 3'b110}) begin
                n_bad++;
                $display("FAIL dontcare[%0d]: got %h/%b want ff/0100110", i, cap_rules[i], {cap_we[i], cap_busy[i], cap_clr[i], cap_done[i]});
            end
        end
        n_cmp++;
        if ({cap_done[33], cap_err[33], cap_busy[33], cap_clr[33], cap_we[33], cap_rules[33], cap_ready[33]} !== {4'b1000, 12'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL dontcare_done: got %b", {cap_done[33], cap_err[33], cap_busy[33], cap_clr[33], cap_we[33], cap_rules[33], cap_ready[33]});
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        issue(3'd1, val_seq(), 40'h0, 8'hFF, 8'hFF);
        dones = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge wclk);
            cap_we[i] = we; cap_rules[i] = rules; cap_done[i] = done; cap_ready[i] = req_ready;
            if (done) dones++;
            if (i == 1) begin
                req_group = 3'd3; req_value = 40'h0; req_mask = 40'hFF_FFFF_FFFF; req_rvalid = 8'h0F;
            end
            if (i == 34) req_valid = 1'b0;
        end
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if ({cap_we[i], cap_rules[i]} !== {4'b0010, diag_rules(32 - i)}) begin
                n_bad++;
                $display("FAIL b2b_first[%0d]: got %b/%h want 0010/%h", i, cap_we[i], cap_rules[i], diag_rules(32 - i));
            end
        end
        n_cmp++;
        if (cap_ready[5] !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_busy: got %b want 0", cap_ready[5]); end
        n_cmp++;
        if ({cap_done[33], cap_ready[33], cap_we[33]} !== 6'b110000) begin
            n_bad++;
            $display("FAIL b2b_done1: got %b want 110000", {cap_done[33], cap_ready[33], cap_we[33]});
        end
        n_cmp++;
        if ({cap_we[34], cap_rules[34]} !== {4'b1000, 8'h0F}) begin
            n_bad++;
            $display("FAIL b2b_second_start: got %b/%h want 1000/0f", cap_we[34], cap_rules[34]);
        end
        n_cmp++;
        if ({cap_done[66], cap_we[65]} !== 5'b11000) begin
            n_bad++;
            $display("FAIL b2b_done2: got %b want 11000", {cap_done[66], cap_we[65]});
        end
        n_cmp++;
        if (dones !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
    endtask

    task automatic test_reset_mid_shift();
        issue(3'd2, 40'h0, 40'h0, 8'hFF, 8'hFF);
        for (int i = 1; i <= 10; i++) begin
            @(negedge wclk);
            if (i == 1) req_valid = 1'b0;
        end
        n_cmp++;
        if ({busy, we} !== 5'b10100) begin n_bad++; $display("FAIL midrst_pre: got %b want 10100", {busy, we}); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, we, rules, clr, busy, done, done_err} !== {1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL midrst_clear: got %b want %b", {req_ready, we, rules, clr, busy, done, done_err}, {1'b1, 16'h0});
        end
        @(negedge wclk);
        rst = 1'b0;
        issue(3'd1, 40'h1F, 40'h0, 8'h01, 8'hFF);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if ({cap_we[i], cap_rules[i], cap_busy[i]} !== {4'b0010, (i == 1) ? 8'h01 : 8'h00, 1'b1}) begin
                n_bad++;
                $display("FAIL midrst_redo[%0d]: got %b/%h/%b", i, cap_we[i], cap_rules[i], cap_busy[i]);
            end
        end
        n_cmp++;
        if ({cap_done[33], cap_err[33], cap_done[32]} !== 3'b100) begin
            n_bad++;
            $display("FAIL midrst_done: got %b want 100", {cap_done[33], cap_err[33], cap_done[32]});
        end
    endtask

    task automatic test_bad_group();
        issue(3'd5, 40'h0, 40'hFF_FFFF_FFFF, 8'hFF, 8'hFF);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if ({cap_we[i], cap_rules[i], cap_busy[i], cap_clr[i], cap_done[i]} !== {4'b0000, 8'hFF, 3'b110}) begin
                n_bad++;
                $display("FAIL badgrp[%0d]: got %b/%h/%b", i, cap_we[i], cap_rules[i], {cap_busy[i], cap_clr[i], cap_done[i]});
            end
        end
        n_cmp++;
        if ({cap_done[33], cap_err[33], cap_busy[33]} !== 3'b110) begin
            n_bad++;
            $display("FAIL badgrp_done: got %b want 110", {cap_done[33], cap_err[33], cap_busy[33]});
        end
    endtask

`ifdef DBLOCK_RULE_WRITER_SHADOW_EN
    task automatic test_shadow();
        logic [39:0] v;
        logic [7:0]  e;
        issue(3'd1, val_seq(), 40'h0, 8'hFF, 8'hFF);
        capture(33);
        for (int i = 1; i <= 32; i++) first_rules[i] = cap_rules[i];
        v = 40'h0;
        v[14:10] = 5'h1F;
        issue(3'd1, v, 40'h0, 8'h04, 8'h04);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            e = diag_rules(32 - i) & 8'hFB;
            if (i == 1) e = e | 8'h04;
            n_cmp++;
            if (cap_rules[i] !== e) begin
                n_bad++;
                $display("FAIL shadow_rules[%0d]: got %h want %h", i, cap_rules[i], e);
            end
            n_cmp++;
            if ((cap_rules[i] & 8'hFB) !== (first_rules[i] & 8'hFB)) begin
                n_bad++;
                $display("FAIL shadow_keep[%0d]: got %h want %h", i, cap_rules[i] & 8'hFB, first_rules[i] & 8'hFB);
            end
        end
    endtask
`else
    task automatic test_rowsel_ignored();
        issue(3'd0, val_seq(), 40'h0, 8'hFF, 8'h00);
        capture(33);
        for (int i = 1; i <= 32; i++) begin
            n_cmp++;
            if (cap_rules[i] !== diag_rules(32 - i)) begin
                n_bad++;
                $display("FAIL rowsel_ignored[%0d]: got %h want %h", i, cap_rules[i], diag_rules(32 - i));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_row();
        test_all_dontcare();
        test_back_to_back();
        test_reset_mid_shift();
        test_bad_group();
`ifdef DBLOCK_RULE_WRITER_SHADOW_EN
        test_shadow();
`else
        test_rowsel_ignored();
`endif
        repeat (2) @(negedge wclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
